// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, the LSU
// state encoding and request legality helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_LOAD_WAIT = 2'd1,
    LSU_RMW_WRITE = 2'd2
  } lsu_state_e;

  // Stores only have signed encodings; loads add the two unsigned ones.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size is carried in funct3[1:0] for every legal encoding.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      2'b10:   return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from the memory
// word, and merges sub-word store data into the word read back for RMW.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed byte/half, then sign- or zero-extend by funct3.
  always_comb begin
    lane_b = rdata[7:0];
    case (addr_lo)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = rdata;
    endcase
  end

  // Overwrite only the addressed lane; everything else keeps the old word.
  always_comb begin
    merge_data = rdata;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1])
          merge_data[31:16] = wdata[15:0];
        else
          merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit in front of a word-wide, registered-read
// data memory. Sub-word stores are done as read-modify-write.
//
// state         | meaning
// LSU_IDLE      | accepting requests; SW completes here in one cycle
// LSU_LOAD_WAIT | memory word arriving; load result presented
// LSU_RMW_WRITE | old word arriving; merged word written back
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        mem_memrw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_write,
  input  logic [31:0] mem_data_read
);

  lsu_state_e  state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;

  logic        req_ok;
  logic        accept;
  logic        is_sw;
  logic [31:0] merge_data;

  // Request decode; everything is gated by rst so reset forces quiet outputs
  // even while the state register still holds a busy state.
  always_comb begin
    req_ok = f3_legal(req_we, req_funct3) && addr_aligned(req_funct3, req_addr[1:0]);
    accept = !rst && (state == LSU_IDLE) && req_valid && req_ok;
    is_sw  = req_we && (req_funct3 == F3_W);

    access_fault   = !rst && (state == LSU_IDLE) && req_valid && !req_ok;
    stall          = accept && !is_sw;
    load_valid     = !rst && (state == LSU_LOAD_WAIT);
    mem_memrw      = (accept && is_sw) || (!rst && (state == LSU_RMW_WRITE));
    mem_address    = (state == LSU_IDLE) ? {req_addr[31:2], 2'b00}
                                         : {lat_addr[31:2], 2'b00};
    mem_data_write = (state == LSU_RMW_WRITE) ? merge_data : req_wdata;
  end

  // State sequencing and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LSU_IDLE;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_f3    <= 3'd0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_f3    <= req_funct3;
            if (!req_we)
              state <= LSU_LOAD_WAIT;
            else if (!is_sw)
              state <= LSU_RMW_WRITE;
          end
        end
        LSU_LOAD_WAIT: state <= LSU_IDLE;
        LSU_RMW_WRITE: state <= LSU_IDLE;
        default:       state <= LSU_IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .funct3     (lat_f3),
    .addr_lo    (lat_addr[1:0]),
    .rdata      (mem_data_read),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small registered-read memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_fault;
  logic        mem_memrw;
  logic [31:0] mem_address;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;

  logic        mem_init;
  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_err    = 0;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .access_fault   (access_fault),
    .mem_memrw      (mem_memrw),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read)
  );

  always #5 clk = ~clk;

  // Word memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem_data_read <= 32'd0;
    end else begin
      if (mem_memrw) mem[mem_address[7:2]] <= mem_data_write;
      mem_data_read <= mem[mem_address[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    @(negedge clk);
    drive(1'b0, f3, addr, 32'h0);
    #1;
    chk({tag, " accept stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " accept memrw"}, {31'd0, mem_memrw}, 32'd0);
    chk({tag, " accept addr"}, mem_address, {addr[31:2], 2'b00});
    chk({tag, " accept lvalid"}, {31'd0, load_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " wait lvalid"}, {31'd0, load_valid}, 32'd1);
    chk({tag, " wait stall"}, {31'd0, stall}, 32'd0);
    chk({tag, " data"}, load_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    drive(1'b1, 3'd2, addr, data);
    #1;
    chk({tag, " stall"}, {31'd0, stall}, 32'd0);
    chk({tag, " memrw"}, {31'd0, mem_memrw}, 32'd1);
    chk({tag, " wdata"}, mem_data_write, data);
    chk({tag, " addr"}, mem_address, {addr[31:2], 2'b00});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_sub(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_word);
    @(negedge clk);
    drive(1'b1, f3, addr, data);
    #1;
    chk({tag, " accept stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " accept memrw"}, {31'd0, mem_memrw}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " rmw memrw"}, {31'd0, mem_memrw}, 32'd1);
    chk({tag, " rmw stall"}, {31'd0, stall}, 32'd0);
    chk({tag, " rmw wdata"}, mem_data_write, exp_word);
    chk({tag, " rmw addr"}, mem_address, {addr[31:2], 2'b00});
    @(posedge clk);
    #1;
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    @(negedge clk);
    drive(we, f3, addr, 32'hFFFF_FFFF);
    #1;
    chk({tag, " fault"}, {31'd0, access_fault}, 32'd1);
    chk({tag, " stall"}, {31'd0, stall}, 32'd0);
    chk({tag, " memrw"}, {31'd0, mem_memrw}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " pulse end"}, {31'd0, access_fault}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    // Reset holds outputs quiet even with an SW request present.
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h10, 32'h1111_1111);
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst lvalid", {31'd0, load_valid}, 32'd0);
    chk("rst fault", {31'd0, access_fault}, 32'd0);
    chk("rst memrw", {31'd0, mem_memrw}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b0;
    chk("rst no write", mem[4], 32'd0);

    // Scenario 1
    do_sw("s1 sw", 32'h10, 32'hDEAD_BEEF);
    chk("s1 mem", mem[4], 32'hDEAD_BEEF);
    do_load("s1 lw", 3'd2, 32'h10, 32'hDEAD_BEEF);

    // Scenario 2
    do_load("s2 lb", 3'd0, 32'h13, 32'hFFFF_FFDE);
    do_load("s2 lbu", 3'd4, 32'h13, 32'h0000_00DE);
    do_load("s2 lh", 3'd1, 32'h12, 32'hFFFF_DEAD);
    do_load("s2 lhu", 3'd5, 32'h10, 32'h0000_BEEF);

    // Scenario 3
    do_sub("s3 sb", 3'd0, 32'h11, 32'h0000_0055, 32'hDEAD_55EF);
    do_load("s3 lw", 3'd2, 32'h10, 32'hDEAD_55EF);

    // Scenario 4: each access follows the previous completion with no gap.
    do_sub("s4 sh", 3'd1, 32'h12, 32'h0000_1234, 32'h1234_55EF);
    do_load("s4 lw", 3'd2, 32'h10, 32'h1234_55EF);
    do_sub("s4 sb", 3'd0, 32'h10, 32'h0000_0000, 32'h1234_5500);
    chk("s4 mem", mem[4], 32'h1234_5500);

    // Scenario 5
    do_fault("s5 lw mis", 1'b0, 3'd2, 32'h11);
    do_fault("s5 sh mis", 1'b1, 3'd1, 32'h13);
    do_fault("s5 ld f3=3", 1'b0, 3'd3, 32'h10);
    do_fault("s5 st f3=4", 1'b1, 3'd4, 32'h10);
    chk("s5 mem", mem[4], 32'h1234_5500);

    // Scenario 6: reset lands on the RMW_WRITE cycle.
    @(negedge clk);
    drive(1'b1, 3'd0, 32'h10, 32'h0000_00AA);
    #1;
    chk("s6 accept stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s6 rst memrw", {31'd0, mem_memrw}, 32'd0);
    chk("s6 rst stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("s6 mem", mem[4], 32'h1234_5500);
    do_load("s6 post-rst lw", 3'd2, 32'h10, 32'h1234_5500);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
